song_seq_ctrl: RTL

Auto-play sequencer for the electronic piano. It steps through a song ROM of (note, duration) entries and drives the tone generator's note code. It counts note durations in beats supplied by the tick divider's 1-cycle enable strobe. It also restarts the tick divider on start so the first note lasts a full beat.

---
 rtl/song_seq_ctrl_pkg.sv | 19 +
 rtl/song_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/song_seq_ctrl_pkg.sv
// Shared definitions for the song auto-play sequencer: marker codes, FSM states
// and the {note, dur} layout of a song ROM word.
package song_seq_ctrl_pkg;

    localparam int unsigned NOTE_REST = 0;
    localparam int unsigned DUR_END   = 0;

    // Duration sits in the low bits of a ROM word; the note code sits directly above it.
    localparam int unsigned DUR_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_FIN
    } seq_state_e;

endpackage

// File: rtl/song_seq_ctrl.sv
// Auto-play sequencer: walks a song ROM of {note, dur} entries, holds each note
// for dur beats of tick_en, and drives the tone generator's note code.
module song_seq_ctrl
    import song_seq_ctrl_pkg::*;
#(
    parameter int unsigned NOTE_W = 5,
    parameter int unsigned DUR_W  = 4,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic                    div_clr,
    output logic [NOTE_W-1:0]       note_out,
    output logic                    note_valid,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    seq_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NOTE_W-1:0] note_q;
    logic [DUR_W-1:0]  cnt_q;
    logic              valid_q;
    logic              div_clr_q;
    logic              done_q;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              beat;
    logic              sound;
    logic              song_end;

    assign rom_dur  = rom_data[DUR_LSB +: DUR_W];
    assign rom_note = rom_data[DUR_LSB + DUR_W +: NOTE_W];

    assign beat  = tick_en && !pause;
    assign sound = (note_q != NOTE_W'(NOTE_REST)) && !pause;

    // The last entry of a full ROM ends the song exactly like an explicit end marker.
    assign song_end = ((state_q == S_LOAD) && (rom_dur == DUR_W'(DUR_END)))
                   || ((state_q == S_PLAY) && beat && (cnt_q == DUR_W'(1))
                       && (addr_q == ADDR_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            div_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            div_clr_q <= 1'b0;
            done_q    <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                note_q  <= '0;
                valid_q <= 1'b0;
            end else if (start) begin
                state_q   <= S_FETCH;
                addr_q    <= '0;
                div_clr_q <= 1'b1;
                note_q    <= '0;
                valid_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_FETCH: begin
                        valid_q <= sound;
                        state_q <= S_LOAD;
                    end
                    S_LOAD, S_PLAY: begin
                        valid_q <= sound;
                        if (song_end) begin
                            if (loop_en) begin
                                addr_q  <= '0;
                                state_q <= S_FETCH;
                            end else begin
                                note_q  <= '0;
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FIN;
                            end
                        end else if (state_q == S_LOAD) begin
                            note_q  <= rom_note;
                            cnt_q   <= rom_dur;
                            valid_q <= (rom_note != NOTE_W'(NOTE_REST)) && !pause;
                            state_q <= S_PLAY;
                        end else if (beat) begin
                            cnt_q <= cnt_q - DUR_W'(1);
                            if (cnt_q == DUR_W'(1)) begin
                                addr_q  <= addr_q + ADDR_W'(1);
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_addr   = addr_q;
    assign div_clr    = div_clr_q;
    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
